game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_pkg.sv | 18 +
 rtl/press_detector.sv | 22 ++
 rtl/game_sequencer.sv | 118 +++++++++++
 tb/tb_game_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the snake game: top-level game state and difficulty.
// Also used by snake_controller.
package game_pkg;

    typedef enum logic [1:0] {
        DIFF_SELECTION = 2'b00,
        PLAYING        = 2'b01,
        WIN            = 2'b10,
        GAME_OVER      = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        EASY   = 2'd0,
        MEDIUM = 2'd1,
        HARD   = 2'd2
    } difficulty_t;

endpackage

// File: rtl/press_detector.sv
// Falling-edge detector for one active-low button.
// History resets to released, so a button held through reset reports one press.
module press_detector (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= 1'b1;
        end else begin
            prev <= button;
        end
    end

    assign press = prev & ~button;

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: difficulty menu, step-rate divider, score counter
// and win/lose handling, all outputs registered.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICKS_EASY   = 8,
    parameter int TICKS_MEDIUM = 4,
    parameter int TICKS_HARD   = 2,
    parameter int WIN_LENGTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               up_button,
    input  logic                               right_button,
    input  logic                               down_button,
    input  logic                               left_button,
    input  logic                               collision,
    input  logic                               food_eaten,
    input  logic [$clog2(WIN_LENGTH+1)-1:0]    snake_length,
    output logic [1:0]                         state,
    output logic [1:0]                         difficulty,
    output logic                               step_tick,
    output logic [7:0]                         score
);

    localparam int LEN_W   = $clog2(WIN_LENGTH + 1);
    localparam int MAX_T01 = (TICKS_EASY > TICKS_MEDIUM) ? TICKS_EASY : TICKS_MEDIUM;
    localparam int MAX_T   = (MAX_T01 > TICKS_HARD) ? MAX_T01 : TICKS_HARD;
    localparam int CNT_W   = (MAX_T > 2) ? $clog2(MAX_T) : 1;

    logic up_press, right_press, down_press, left_press, any_press;

    press_detector u_up    (.clk(clk), .rst(rst), .button(up_button),    .press(up_press));
    press_detector u_right (.clk(clk), .rst(rst), .button(right_button), .press(right_press));
    press_detector u_down  (.clk(clk), .rst(rst), .button(down_button),  .press(down_press));
    press_detector u_left  (.clk(clk), .rst(rst), .button(left_button),  .press(left_press));

    assign any_press = up_press | right_press | down_press | left_press;

    game_state_t       state_q, state_d;
    difficulty_t       diff_q, diff_d;
    logic [7:0]        score_q, score_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              tick_q, tick_d;
    logic [CNT_W-1:0]  step_limit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIFF_SELECTION;
            diff_q  <= EASY;
            score_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            score_q <= score_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        case (diff_q)
            EASY:    step_limit = CNT_W'(TICKS_EASY - 1);
            MEDIUM:  step_limit = CNT_W'(TICKS_MEDIUM - 1);
            default: step_limit = CNT_W'(TICKS_HARD - 1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        score_d = score_q;
        count_d = '0;
        tick_d  = 1'b0;
        case (state_q)
            DIFF_SELECTION: begin
                if (up_press && !down_press && diff_q != HARD) begin
                    diff_d = difficulty_t'(diff_q + 2'd1);
                end else if (down_press && !up_press && diff_q != EASY) begin
                    diff_d = difficulty_t'(diff_q - 2'd1);
                end
                if (right_press) begin
                    state_d = PLAYING;
                end
            end
            PLAYING: begin
                if (food_eaten && score_q != 8'hFF) begin
                    score_d = score_q + 8'd1;
                end
                // Leaving PLAYING suppresses the tick and parks the counter at 0.
                if (collision) begin
                    state_d = GAME_OVER;
                end else if (snake_length >= LEN_W'(WIN_LENGTH)) begin
                    state_d = WIN;
                end else if (count_q == step_limit) begin
                    tick_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            WIN, GAME_OVER: begin
                if (any_press) begin
                    state_d = DIFF_SELECTION;
                    score_d = '0;
                end
            end
            default: state_d = DIFF_SELECTION;
        endcase
    end

    assign state      = state_q;
    assign difficulty = diff_q;
    assign step_tick  = tick_q;
    assign score      = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: cycle-level behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_game_sequencer;

    localparam int TE = 8;
    localparam int TM = 4;
    localparam int TH = 2;
    localparam int WL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;            // {left, down, right, up}, active low
    logic       collision;
    logic       food;
    logic [4:0] len;
    logic [1:0] state;
    logic [1:0] difficulty;
    logic       step_tick;
    logic [7:0] score;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    // behavioural model
    int         m_state = 0, m_diff = 0, m_score = 0, m_elapsed = 0;
    int         m_tick = 0;
    logic [3:0] m_hist = 4'hF;
    logic [3:0] m_pr;

    always #5 clk = ~clk;

    game_sequencer #(
        .TICKS_EASY(TE),
        .TICKS_MEDIUM(TM),
        .TICKS_HARD(TH),
        .WIN_LENGTH(WL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .up_button(btn[0]),
        .right_button(btn[1]),
        .down_button(btn[2]),
        .left_button(btn[3]),
        .collision(collision),
        .food_eaten(food),
        .snake_length(len),
        .state(state),
        .difficulty(difficulty),
        .step_tick(step_tick),
        .score(score)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int ticks_for(input int d);
        return (d == 0) ? TE : (d == 1) ? TM : TH;
    endfunction

    task automatic model_reset();
        m_state = 0; m_diff = 0; m_score = 0; m_elapsed = 0; m_tick = 0; m_hist = 4'hF;
    endtask

    // One clock of game rules, evaluated on the inputs that were present at the edge.
    task automatic model_step();
        m_pr   = m_hist & ~btn;
        m_tick = 0;
        case (m_state)
            0: begin
                if (m_pr[0] && !m_pr[2] && m_diff < 2) m_diff++;
                else if (m_pr[2] && !m_pr[0] && m_diff > 0) m_diff--;
                if (m_pr[1]) begin
                    m_state   = 1;
                    m_elapsed = 0;
                end
            end
            1: begin
                if (food && m_score < 255) m_score++;
                if (collision) m_state = 3;
                else if (int'(len) >= WL) m_state = 2;
                else begin
                    m_elapsed++;
                    m_tick = (m_elapsed % ticks_for(m_diff) == 0) ? 1 : 0;
                end
            end
            default: begin
                if (m_pr != 4'h0) begin
                    m_state = 0;
                    m_score = 0;
                end
            end
        endcase
        m_hist = btn;
    endtask

    always @(negedge rst) model_reset();

    always @(posedge clk) begin
        #1;
        if (started) begin
            if (!rst) model_reset();
            else model_step();
            check("state", 32'(state), 32'(m_state));
            check("difficulty", 32'(difficulty), 32'(m_diff));
            check("step_tick", 32'(step_tick), 32'(m_tick));
            check("score", 32'(score), 32'(m_score));
        end
    end

    task automatic press(input int idx);
        btn[idx] = 1'b0;
        @(negedge clk);
        btn[idx] = 1'b1;
        @(negedge clk);
    endtask

    task automatic food_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            food = 1'b1;
            @(negedge clk);
            food = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; btn = 4'hF; collision = 1'b0; food = 1'b0; len = 5'd3;
        #2 rst = 1'b0;
        started = 1;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_diff", 32'(difficulty), 0);
        check("rst_tick", 32'(step_tick), 0);
        check("rst_score", 32'(score), 0);
        rst = 1'b1;

        // three ups saturate at HARD, then start
        press(0); press(0); press(0);
        check("up_sat_diff", 32'(difficulty), 2);
        btn[1] = 1'b0;
        @(negedge clk);
        btn[1] = 1'b1;
        check("start_state", 32'(state), 1);
        check("start_diff", 32'(difficulty), 2);
        check("start_tick0", 32'(step_tick), 0);
        @(negedge clk); check("hard_tick1", 32'(step_tick), 0);
        @(negedge clk); check("hard_tick2", 32'(step_tick), 1);
        @(negedge clk); check("hard_tick3", 32'(step_tick), 0);
        @(negedge clk); check("hard_tick4", 32'(step_tick), 1);
        repeat (6) @(negedge clk);

        // held down button decrements once only
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        press(0);
        check("menu_diff1", 32'(difficulty), 1);
        btn[2] = 1'b0;
        @(negedge clk);
        check("held_down_first", 32'(difficulty), 0);
        repeat (19) @(negedge clk);
        check("held_down_last", 32'(difficulty), 0);
        check("held_down_state", 32'(state), 0);
        btn[2] = 1'b1;
        @(negedge clk);

        // up+down cancel; right+down applies and starts
        press(0);
        btn[0] = 1'b0; btn[2] = 1'b0;
        @(negedge clk);
        btn = 4'hF;
        @(negedge clk);
        check("updown_cancel", 32'(difficulty), 1);
        btn[1] = 1'b0; btn[2] = 1'b0;
        @(negedge clk);
        btn = 4'hF;
        check("right_down_state", 32'(state), 1);
        check("right_down_diff", 32'(difficulty), 0);

        // score saturation at EASY
        food_pulses(300);
        check("score_sat", 32'(score), 255);

        // collision wins over length
        collision = 1'b1; len = 5'd16;
        @(negedge clk);
        check("both_state", 32'(state), 3);
        check("both_tick", 32'(step_tick), 0);
        collision = 1'b0; len = 5'd3;
        repeat (3) @(negedge clk);
        check("over_score_held", 32'(score), 255);
        btn[3] = 1'b0;
        @(negedge clk);
        btn[3] = 1'b1;
        check("left_exit_state", 32'(state), 0);
        check("left_exit_score", 32'(score), 0);
        check("left_exit_diff", 32'(difficulty), 0);
        @(negedge clk);

        // win at MEDIUM, exit with held down that must not retrigger
        press(0);
        btn[1] = 1'b0;
        @(negedge clk);
        check("med_start", 32'(state), 1);
        repeat (3) @(negedge clk);
        btn[1] = 1'b1;
        food_pulses(3);
        len = 5'd16;
        @(negedge clk);
        len = 5'd3;
        check("win_state", 32'(state), 2);
        check("win_tick", 32'(step_tick), 0);
        check("win_score", 32'(score), 3);
        btn[2] = 1'b0;
        @(negedge clk);
        check("win_exit_state", 32'(state), 0);
        check("win_exit_score", 32'(score), 0);
        check("win_exit_diff", 32'(difficulty), 1);
        repeat (3) @(negedge clk);
        check("no_retrigger_diff", 32'(difficulty), 1);
        btn[2] = 1'b1;
        @(negedge clk);

        // asynchronous reset mid-game, up held through release
        press(1);
        food_pulses(2);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_state", 32'(state), 0);
        check("async_score", 32'(score), 0);
        check("async_diff", 32'(difficulty), 0);
        check("async_tick", 32'(step_tick), 0);
        btn[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("held_thru_rst", 32'(difficulty), 1);
        repeat (3) @(negedge clk);
        check("held_thru_rst_once", 32'(difficulty), 1);
        btn[0] = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
